// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/result handshake bundle for the bit-serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial unsigned subtractor, one result bit per clock
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic [WIDTH-2:0]  r_sh;
    logic              r_br;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_diff;
    logic              r_borrow;
    logic              r_zero;
    logic              r_done;

    logic              w_load;
    logic              w_step;
    logic              w_last;
    logic              w_x;
    logic              w_y;
    logic              w_d;
    logic              w_br_next;
    logic [WIDTH-1:0]  w_sh_next;

    // Single-bit subtract cell; the borrow FF carries between cycles.
    assign w_x       = r_a_sh[0];
    assign w_y       = r_b_sh[0];
    assign w_d       = w_x ^ w_y ^ r_br;
    assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
    // Only the WIDTH-1 most recent bits are stored; the newest bit completes the word.
    assign w_sh_next = {w_d, r_sh};

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_last       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sh     <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_last;
            if (w_load) begin
                r_a_sh <= bus.a;
                r_b_sh <= bus.b;
                r_sh   <= '0;
                r_br   <= 1'b0;
                r_cnt  <= '0;
            end else if (w_step) begin
                r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                r_sh   <= w_sh_next[WIDTH-1:1];
                r_br   <= w_br_next;
                r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
            end
            // Visible outputs change only when a full word is ready.
            if (w_last) begin
                r_diff   <= w_sh_next;
                r_borrow <= w_br_next;
                r_zero   <= (w_sh_next == '0);
            end
        end
    end

    assign bus.busy       = (r_state == ST_RUN);
    assign bus.done       = r_done;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow;
    assign bus.zero       = r_zero;
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first unsigned subtractor. It computes diff = a - b (mod 2^WIDTH), plus the borrow-out, one bit per clock.
- It is the sequential counterpart to the combinational half-adder datapath: a single-bit subtract cell plus a borrow flip-flop is reused for WIDTH cycles.
- A start/busy/done handshake lets a controller or bench launch operations and collect results.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range 2..32.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when results update.
- diff  output  WIDTH  registered result (a - b) mod 2^WIDTH.
- borrow_out  output  1  registered final borrow; 1 iff a < b (unsigned).
- zero  output  1  registered; 1 iff diff == 0.

Behaviour:
- Reset: the interface is one clock, with synchronous active-low reset rst_n.
  - rst_n low at a rising edge forces state IDLE.
  - It also clears busy, done, diff, borrow_out, zero, and the internal shift registers, borrow FF and bit counter.
  - Reset has priority over every other input, including mid-operation; any partial result is discarded.
- State IDLE:
  - busy=0.
  - If start=1 at an edge: load a_sh<=a and b_sh<=b, clear borrow FF, clear counter, clear internal r_sh, go to RUN.
  - If start=0: stay in IDLE.
- State RUN:
  - busy=1.
  - Each edge, with x=a_sh[0], y=b_sh[0], br=borrow FF:
    - d = x ^ y ^ br.
    - br_next = (~x & y) | (~(x ^ y) & br).
    - r_sh <= {d, r_sh[WIDTH-1:1]}.
    - a_sh and b_sh shift right by 1.
    - counter increments.
  - On the edge that processes bit WIDTH-1 (counter == WIDTH-1):
    - diff <= final r_sh value including d.
    - borrow_out <= br_next.
    - zero <= (final value == 0).
    - done <= 1, state <= IDLE.
- done: high for exactly one cycle after the completing edge; cleared at the next edge.
- Latency: start accepted at edge E0; bits processed at edges E1..E_WIDTH. busy is high after E0 through E_WIDTH. done, diff, borrow_out and zero become valid after E_WIDTH. Total WIDTH+1 edges from start to result.
- Output stability: diff, borrow_out and zero hold their value until the next completed operation or reset. They never show partial results.
- start while busy: ignored. The operation in flight is unaffected, and a and b changes are also ignored after capture.
- Back-to-back: in the cycle where done=1, state is IDLE, so start=1 is accepted at that edge. This allows one operation every WIDTH+1 cycles.
- Counter width: $clog2(WIDTH). No wrap beyond WIDTH-1.
- Arithmetic: pure unsigned two-operand subtract. No borrow-in and no signed overflow flag.

Test Plan (WIDTH=8):
- Basic: a=0x5A, b=0x23, start one cycle → busy for 8 cycles; done pulse after the 9th edge; diff=0x37, borrow_out=0, zero=0.
- Underflow: a=0x10, b=0x20 → diff=0xF0, borrow_out=1. Also a=0x00, b=0x01 → diff=0xFF, borrow_out=1 (full borrow ripple).
- Equal operands: a=0xFF, b=0xFF → diff=0x00, borrow_out=0, zero=1. Then a=0xFF, b=0x00 → diff=0xFF, zero=0.
- Start during busy: start with a=0x80, b=0x01, then start=1 again at cycle 3 with a=0x00, b=0xFF → single done pulse; diff=0x7F, borrow_out=0.
- Reset mid-op: start with a=0x5A, b=0x23, drop rst_n for one edge at cycle 4 → busy=0 and diff=0 immediately after that edge; no done pulse. A new start then completes normally.
- Back-to-back: hold start=1 continuously with alternating operands (0x5A−0x23, then 0x10−0x20) → done every 9 cycles; results 0x37/0 then 0xF0/1. diff stays stable between pulses.
